// File: rtl/ppu_sprite_line_engine.sv
// Per-scanline sprite engine: scans OAM in hblank, fetches one graphics row per selected slot,
// then emits the prioritised sprite pixel per active pixel. Optional macro: SPRITE_ZERO_HIT_EN.
module ppu_sprite_line_engine #(
    parameter int unsigned NUM_OAM     = 64,
    parameter int unsigned NUM_SPRITES = 8,
    parameter int unsigned OAM_AW      = 8
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_eval_start,
    input  logic [7:0]        i_eval_line,
    input  logic              i_line_go,
    input  logic              i_pix_en,
    output logic [OAM_AW-1:0] o_oam_addr,
    input  logic [31:0]       i_oam_rdata,
    output logic [10:0]       o_gfx_addr,
    input  logic [31:0]       i_gfx_rdata,
    output logic              o_busy,
    output logic              o_ready,
    output logic              o_overflow,
    output logic              o_pix_valid,
    output logic [1:0]        o_pix_data,
    output logic [2:0]        o_pix_palette
`ifdef SPRITE_ZERO_HIT_EN
    ,
    input  logic              i_bg_opaque,
    output logic              o_sprite0_hit
`endif
);

    localparam int unsigned CW = $clog2(NUM_SPRITES + 1);
    localparam int unsigned SW = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;

    typedef enum logic [1:0] {StIdle, StScan, StFetch, StDone} state_e;
    state_e r_state, w_state_next;

    logic [7:0]        r_line;
    logic [OAM_AW-1:0] r_oam_addr;
    logic              r_issuing, r_chk_vld, r_chk_last;
    logic [CW-1:0]     r_count, r_fetch_idx;
    logic [SW-1:0]     r_cap_idx;
    logic              r_cap_vld, r_cap_last;
    logic              r_ready, r_overflow;
    logic [8:0]        r_x_cnt;
    logic              r_pix_valid;
    logic [1:0]        r_pix_data;
    logic [2:0]        r_pix_pal;

    // Prepared bank (filled during evaluation) and active bank (used for the current line)
    logic [NUM_SPRITES-1:0] r_p_vld;
    logic [7:0]             r_p_x     [NUM_SPRITES];
    logic [6:0]             r_p_tile  [NUM_SPRITES];
    logic [3:0]             r_p_row   [NUM_SPRITES];
    logic [2:0]             r_p_pal   [NUM_SPRITES];
    logic                   r_p_hflip [NUM_SPRITES];
    logic [31:0]            r_p_gfx   [NUM_SPRITES];
    logic [NUM_SPRITES-1:0] r_a_vld;
    logic [7:0]             r_a_x     [NUM_SPRITES];
    logic [2:0]             r_a_pal   [NUM_SPRITES];
    logic                   r_a_hflip [NUM_SPRITES];
    logic [31:0]            r_a_gfx   [NUM_SPRITES];

`ifdef SPRITE_ZERO_HIT_EN
    logic r_chk_first, r_p_s0, r_a_s0, r_s0_hit;
`endif

    logic [7:0] w_dy;
    logic       w_hit, w_full, w_take, w_fetch_issue, w_eval_go;
    logic [1:0] w_cand [NUM_SPRITES];
    logic       w_win_found;
    logic [1:0] w_win_pix;
    logic [2:0] w_win_pal;
    logic       w_unused;

    assign w_unused      = ^i_oam_rdata[31:28];
    assign w_dy          = r_line - i_oam_rdata[15:8];
    assign w_hit         = r_chk_vld && (w_dy[7:4] == 4'd0);
    assign w_full        = (r_count == CW'(NUM_SPRITES));
    assign w_take        = w_hit && !w_full;
    assign w_fetch_issue = (r_state == StFetch) && (r_fetch_idx < r_count);
    assign w_eval_go     = (r_state == StIdle) && i_eval_start;

    assign o_oam_addr    = r_oam_addr;
    assign o_gfx_addr    = w_fetch_issue ? {r_p_tile[r_fetch_idx[SW-1:0]],
                                            r_p_row[r_fetch_idx[SW-1:0]]} : 11'd0;
    assign o_busy        = (r_state != StIdle);
    assign o_ready       = r_ready;
    assign o_overflow    = r_overflow;
    assign o_pix_valid   = r_pix_valid;
    assign o_pix_data    = r_pix_data;
    assign o_pix_palette = r_pix_pal;
`ifdef SPRITE_ZERO_HIT_EN
    assign o_sprite0_hit = r_s0_hit;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= StIdle;
        else         r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (i_eval_start) w_state_next = StScan;
            // Zero hits skips the fetch phase entirely
            StScan:  if (r_chk_vld && r_chk_last)
                         w_state_next = ((r_count == '0) && !w_take) ? StDone : StFetch;
            StFetch: if (r_cap_vld && r_cap_last) w_state_next = StDone;
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // Per-slot candidate: 9-bit distance so sprites near x=255 never wrap to x=0
    for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_slot
        logic [8:0] w_dx;
        logic [3:0] w_p;
        assign w_dx = r_x_cnt - {1'b0, r_a_x[g]};
        assign w_p  = r_a_hflip[g] ? ~w_dx[3:0] : w_dx[3:0];
        assign w_cand[g] = (r_a_vld[g] && (w_dx[8:4] == 5'd0)) ?
                           r_a_gfx[g][{w_p, 1'b0} +: 2] : 2'b00;
    end

    always_comb begin
        w_win_found = 1'b0;
        w_win_pix   = 2'b00;
        w_win_pal   = 3'b000;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            if (!w_win_found && (w_cand[i] != 2'b00)) begin
                w_win_found = 1'b1;
                w_win_pix   = w_cand[i];
                w_win_pal   = r_a_pal[i];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_line      <= '0;
            r_oam_addr  <= '0;
            r_issuing   <= 1'b0;
            r_chk_vld   <= 1'b0;
            r_chk_last  <= 1'b0;
            r_count     <= '0;
            r_fetch_idx <= '0;
            r_cap_idx   <= '0;
            r_cap_vld   <= 1'b0;
            r_cap_last  <= 1'b0;
            r_ready     <= 1'b0;
            r_overflow  <= 1'b0;
            r_x_cnt     <= '0;
            r_pix_valid <= 1'b0;
            r_pix_data  <= '0;
            r_pix_pal   <= '0;
            r_p_vld     <= '0;
            r_a_vld     <= '0;
            for (int i = 0; i < NUM_SPRITES; i++) begin
                r_p_x[i]     <= '0;
                r_p_tile[i]  <= '0;
                r_p_row[i]   <= '0;
                r_p_pal[i]   <= '0;
                r_p_hflip[i] <= 1'b0;
                r_p_gfx[i]   <= '0;
                r_a_x[i]     <= '0;
                r_a_pal[i]   <= '0;
                r_a_hflip[i] <= 1'b0;
                r_a_gfx[i]   <= '0;
            end
`ifdef SPRITE_ZERO_HIT_EN
            r_chk_first <= 1'b0;
            r_p_s0      <= 1'b0;
            r_a_s0      <= 1'b0;
            r_s0_hit    <= 1'b0;
`endif
        end else begin
            // Swap reads the old prepared bank, so a coincident eval_start clears it afterwards
            if (i_line_go) begin
                r_a_vld <= r_ready ? r_p_vld : '0;
                for (int i = 0; i < NUM_SPRITES; i++) begin
                    r_a_x[i]     <= r_p_x[i];
                    r_a_pal[i]   <= r_p_pal[i];
                    r_a_hflip[i] <= r_p_hflip[i];
                    r_a_gfx[i]   <= r_p_gfx[i];
                end
`ifdef SPRITE_ZERO_HIT_EN
                r_a_s0 <= r_p_s0;
`endif
                r_ready <= 1'b0;
                r_x_cnt <= '0;
            end else if (i_pix_en && (r_x_cnt != 9'h1FF)) begin
                r_x_cnt <= r_x_cnt + 9'd1;
            end

            if (w_eval_go) begin
                r_line      <= i_eval_line;
                r_oam_addr  <= '0;
                r_issuing   <= 1'b1;
                r_chk_vld   <= 1'b0;
                r_count     <= '0;
                r_fetch_idx <= '0;
                r_cap_vld   <= 1'b0;
                r_p_vld     <= '0;
                r_ready     <= 1'b0;
                r_overflow  <= 1'b0;
`ifdef SPRITE_ZERO_HIT_EN
                r_p_s0 <= 1'b0;
                if (i_eval_line == 8'd0) r_s0_hit <= 1'b0;
`endif
            end

            if (r_state == StScan) begin
                r_chk_vld  <= r_issuing;
                r_chk_last <= r_issuing && (r_oam_addr == OAM_AW'(NUM_OAM - 1));
`ifdef SPRITE_ZERO_HIT_EN
                r_chk_first <= r_issuing && (r_oam_addr == '0);
`endif
                if (r_issuing) begin
                    if (r_oam_addr == OAM_AW'(NUM_OAM - 1)) r_issuing <= 1'b0;
                    else                                    r_oam_addr <= r_oam_addr + 1'b1;
                end
                if (w_take) begin
                    r_p_vld[r_count[SW-1:0]]   <= 1'b1;
                    r_p_x[r_count[SW-1:0]]     <= i_oam_rdata[7:0];
                    r_p_tile[r_count[SW-1:0]]  <= i_oam_rdata[22:16];
                    r_p_row[r_count[SW-1:0]]   <= i_oam_rdata[27] ? ~w_dy[3:0] : w_dy[3:0];
                    r_p_pal[r_count[SW-1:0]]   <= i_oam_rdata[25:23];
                    r_p_hflip[r_count[SW-1:0]] <= i_oam_rdata[26];
                    r_count                    <= r_count + CW'(1);
`ifdef SPRITE_ZERO_HIT_EN
                    if (r_chk_first) r_p_s0 <= 1'b1;
`endif
                end
                if (w_hit && w_full) r_overflow <= 1'b1;
            end

            if (r_state == StFetch) begin
                r_cap_vld  <= w_fetch_issue;
                r_cap_idx  <= r_fetch_idx[SW-1:0];
                r_cap_last <= w_fetch_issue && (r_fetch_idx == r_count - CW'(1));
                if (w_fetch_issue) r_fetch_idx <= r_fetch_idx + CW'(1);
                if (r_cap_vld)     r_p_gfx[r_cap_idx] <= i_gfx_rdata;
            end

            if (r_state == StDone) r_ready <= 1'b1;

            r_pix_valid <= i_pix_en;
            if (i_pix_en) begin
                r_pix_data <= w_win_pix;
                r_pix_pal  <= w_win_pal;
`ifdef SPRITE_ZERO_HIT_EN
                if (r_a_s0 && (w_cand[0] != 2'b00) && i_bg_opaque) r_s0_hit <= 1'b1;
`endif
            end
        end
    end

endmodule

// File: tb/tb_ppu_sprite_line_engine.sv
// Bench for ppu_sprite_line_engine: OAM/graphics memories plus a line-level reference model
// computed from the sprite selection and priority rules.
module tb_ppu_sprite_line_engine;

    localparam int NOAM = 64;
    localparam int NS   = 8;

    logic        clk = 1'b0;
    logic        reset, eval_start, line_go, pix_en;
    logic [7:0]  eval_line;
    logic [7:0]  oam_addr;
    logic [31:0] oam_rdata, gfx_rdata;
    logic [10:0] gfx_addr;
    logic        busy, ready, overflow, pix_valid;
    logic [1:0]  pix_data;
    logic [2:0]  pix_palette;
`ifdef SPRITE_ZERO_HIT_EN
    logic        bg_opaque, sprite0_hit;
`endif

    logic [31:0] oam [NOAM];
    logic [31:0] gfx [2048];
    logic [1:0]  exp_pix [512];
    logic [2:0]  exp_pal [512];
    logic        exp_ovf;
    int          n_tests = 0;
    int          n_fail = 0;
    int          eval_cycles;
    bit          seen_gfx_032;

    ppu_sprite_line_engine #(.NUM_OAM(NOAM), .NUM_SPRITES(NS), .OAM_AW(8)) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_eval_start (eval_start),
        .i_eval_line  (eval_line),
        .i_line_go    (line_go),
        .i_pix_en     (pix_en),
        .o_oam_addr   (oam_addr),
        .i_oam_rdata  (oam_rdata),
        .o_gfx_addr   (gfx_addr),
        .i_gfx_rdata  (gfx_rdata),
        .o_busy       (busy),
        .o_ready      (ready),
        .o_overflow   (overflow),
        .o_pix_valid  (pix_valid),
        .o_pix_data   (pix_data),
        .o_pix_palette(pix_palette)
`ifdef SPRITE_ZERO_HIT_EN
        ,
        .i_bg_opaque  (bg_opaque),
        .o_sprite0_hit(sprite0_hit)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        oam_rdata <= oam[oam_addr[5:0]];
        gfx_rdata <= gfx[gfx_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_entry(input int idx, input logic [7:0] x, input logic [7:0] y,
                             input logic [6:0] tile, input logic [2:0] pal,
                             input logic hf, input logic vf);
        oam[idx] = {4'b0, vf, hf, pal, tile, y, x};
    endtask

    task automatic clear_oam(input logic [7:0] line);
        logic [7:0] y_far;
        y_far = line + 8'd128;
        for (int e = 0; e < NOAM; e++) oam[e] = {16'h0, y_far, 8'h00};
    endtask

    // Reference: first NS hitting entries in OAM order; earliest selected opaque pixel wins
    task automatic model(input logic [7:0] line);
        int          sel[$];
        logic [7:0]  dy;
        logic [31:0] ent, word;
        int          sx, p, row, c;
        exp_ovf = 1'b0;
        for (int e = 0; e < NOAM; e++) begin
            dy = line - oam[e][15:8];
            if (dy < 8'd16) begin
                if (sel.size() < NS) sel.push_back(e);
                else exp_ovf = 1'b1;
            end
        end
        for (int x = 0; x < 512; x++) begin
            exp_pix[x] = 2'd0;
            exp_pal[x] = 3'd0;
            foreach (sel[k]) begin
                ent = oam[sel[k]];
                sx  = int'(ent[7:0]);
                if (exp_pix[x] == 2'd0 && x >= sx && x < sx + 16) begin
                    p = x - sx;
                    if (ent[26]) p = 15 - p;
                    dy  = line - ent[15:8];
                    row = int'(dy);
                    if (ent[27]) row = 15 - row;
                    word = gfx[int'(ent[22:16]) * 16 + row];
                    c = int'((word >> (2 * p)) & 32'd3);
                    if (c != 0) begin
                        exp_pix[x] = c[1:0];
                        exp_pal[x] = ent[25:23];
                    end
                end
            end
        end
    endtask

    task automatic zero_expect();
        for (int x = 0; x < 512; x++) begin
            exp_pix[x] = 2'd0;
            exp_pal[x] = 3'd0;
        end
    endtask

    task automatic start_eval(input logic [7:0] line);
        eval_line  = line;
        eval_start = 1'b1;
        tick();
        eval_start = 1'b0;
        eval_cycles = 0;
    endtask

    task automatic wait_ready(input string name, input int budget);
        while (!ready && eval_cycles < budget) begin
            if (gfx_addr == 11'h032) seen_gfx_032 = 1'b1;
            tick();
            eval_cycles++;
        end
        n_tests++;
        if (ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s ready_timeout: ready=%b after %0d cycles, required 1 within %0d",
                     name, ready, eval_cycles, budget);
        end
    endtask

    task automatic run_line(input string name, input bit do_go);
        int x;
        if (do_go) begin
            line_go = 1'b1;
            tick();
            line_go = 1'b0;
        end
        x = 0;
        while (x < 280) begin
            if (x > 0 && $urandom_range(0, 7) == 0) begin
                pix_en = 1'b0;
                tick();
                n_tests++;
                if (pix_valid !== 1'b0 || pix_data !== exp_pix[x-1] || pix_palette !== exp_pal[x-1]) begin
                    n_fail++;
                    $display("FAIL %s hold x=%0d: valid=%b data=%0d pal=%0d, required 0/%0d/%0d",
                             name, x, pix_valid, pix_data, pix_palette, exp_pix[x-1], exp_pal[x-1]);
                end
            end else begin
                pix_en = 1'b1;
                tick();
                n_tests++;
                if (pix_valid !== 1'b1 || pix_data !== exp_pix[x] || pix_palette !== exp_pal[x]) begin
                    n_fail++;
                    $display("FAIL %s pixel x=%0d: valid=%b data=%0d pal=%0d, required 1/%0d/%0d",
                             name, x, pix_valid, pix_data, pix_palette, exp_pix[x], exp_pal[x]);
                end
                x++;
            end
        end
        pix_en = 1'b0;
    endtask

    task automatic check_ovf(input string name);
        n_tests++;
        if (overflow !== exp_ovf) begin
            n_fail++;
            $display("FAIL %s overflow: got %b, required %b", name, overflow, exp_ovf);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_tests++;
        if ({busy, ready, overflow, pix_valid} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_flags: busy=%b ready=%b ovf=%b valid=%b, required all 0",
                     busy, ready, overflow, pix_valid);
        end
        n_tests++;
        if ({pix_data, pix_palette} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_pixel: data=%0d pal=%0d, required 0/0", pix_data, pix_palette);
        end
        n_tests++;
        if (oam_addr !== 8'd0 || gfx_addr !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_addr: oam=%0h gfx=%0h, required 0/0", oam_addr, gfx_addr);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single();
        clear_oam(8'd12);
        set_entry(5, 8'd20, 8'd10, 7'd3, 3'd2, 1'b0, 1'b0);
        gfx[3 * 16 + 2] = 32'h5555_5555;
        model(8'd12);
        seen_gfx_032 = 1'b0;
        start_eval(8'd12);
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single busy: got %b, required 1", busy);
        end
        wait_ready("single", NOAM + NS + 3);
        n_tests++;
        if (seen_gfx_032 !== 1'b1) begin
            n_fail++;
            $display("FAIL single gfx_addr: 0x032 seen=%b, required 1", seen_gfx_032);
        end
        check_ovf("single");
        run_line("single", 1'b1);
    endtask

    task automatic test_overflow();
        clear_oam(8'd0);
        for (int e = 0; e < 10; e++) begin
            set_entry(e, 8'(e * 20), 8'd0, 7'(e + 10), 3'(e % 8), 1'b0, 1'b0);
            gfx[(e + 10) * 16] = 32'hFFFF_FFFF;
        end
        model(8'd0);
        start_eval(8'd0);
        wait_ready("overflow", 75);
        check_ovf("overflow");
        run_line("overflow", 1'b1);
    endtask

    task automatic test_priority();
        clear_oam(8'd50);
        set_entry(2, 8'd40, 8'd50, 7'd20, 3'd1, 1'b0, 1'b0);
        set_entry(7, 8'd40, 8'd50, 7'd21, 3'd5, 1'b0, 1'b0);
        gfx[20 * 16] = 32'h0;
        gfx[21 * 16] = 32'hFFFF_FFFF;
        model(8'd50);
        start_eval(8'd50);
        wait_ready("prio_a", NOAM + NS + 3);
        run_line("prio_a", 1'b1);
        gfx[20 * 16] = 32'hAAAA_AAAA;
        model(8'd50);
        start_eval(8'd50);
        wait_ready("prio_b", NOAM + NS + 3);
        run_line("prio_b", 1'b1);
    endtask

    task automatic test_wrap_flip();
        logic [1:0] flips [3];
        flips[0] = 2'b00;
        flips[1] = 2'b01;
        flips[2] = 2'b10;
        gfx[9 * 16 + 9] = 32'h0000_0003;
        gfx[9 * 16 + 6] = 32'hC000_0000;
        for (int k = 0; k < 3; k++) begin
            clear_oam(8'd3);
            set_entry(0, 8'd0, 8'd250, 7'd9, 3'd6, flips[k][1], flips[k][0]);
            model(8'd3);
            start_eval(8'd3);
            wait_ready("wrap", NOAM + NS + 3);
            run_line("wrap", 1'b1);
        end
    endtask

    task automatic test_line_go_early();
        clear_oam(8'd12);
        set_entry(5, 8'd20, 8'd10, 7'd3, 3'd2, 1'b0, 1'b0);
        start_eval(8'd12);
        wait_ready("early_prep", NOAM + NS + 3);
        line_go = 1'b1;
        tick();
        line_go = 1'b0;
        start_eval(8'd12);
        for (int i = 0; i < 5; i++) tick();
        zero_expect();
        run_line("early", 1'b1);
        wait_ready("early_finish", 10);
    endtask

    task automatic test_reset_mid();
        clear_oam(8'd12);
        set_entry(5, 8'd20, 8'd10, 7'd3, 3'd2, 1'b0, 1'b0);
        start_eval(8'd12);
        wait_ready("rst_prep", NOAM + NS + 3);
        line_go = 1'b1;
        tick();
        line_go = 1'b0;
        start_eval(8'd12);
        for (int i = 0; i < 10; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_tests++;
        if (busy !== 1'b0 || ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: busy=%b ready=%b, required 0/0", busy, ready);
        end
        zero_expect();
        run_line("reset_mid", 1'b0);
    endtask

    task automatic test_random();
        logic [7:0] line;
        for (int it = 0; it < 6; it++) begin
            line = 8'($urandom_range(0, 255));
            clear_oam(line);
            for (int e = 0; e < NOAM; e++) begin
                if ($urandom_range(0, 4) == 0)
                    set_entry(e, 8'($urandom_range(0, 255)), line - 8'($urandom_range(0, 20)),
                              7'($urandom_range(0, 127)), 3'($urandom_range(0, 7)),
                              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
            model(line);
            start_eval(line);
            wait_ready("random", NOAM + NS + 3);
            check_ovf("random");
            run_line("random", 1'b1);
        end
    endtask

`ifdef SPRITE_ZERO_HIT_EN
    task automatic test_sprite_zero();
        clear_oam(8'd7);
        set_entry(0, 8'd30, 8'd7, 7'd40, 3'd1, 1'b0, 1'b0);
        gfx[40 * 16] = 32'h0000_0003;
        start_eval(8'd7);
        wait_ready("s0_prep", NOAM + NS + 3);
        line_go = 1'b1;
        tick();
        line_go = 1'b0;
        for (int x = 0; x <= 40; x++) begin
            bg_opaque = (x == 30);
            pix_en = 1'b1;
            tick();
            n_tests++;
            if (sprite0_hit !== (x >= 30)) begin
                n_fail++;
                $display("FAIL s0_hit x=%0d: got %b, required %b", x, sprite0_hit, (x >= 30));
            end
        end
        pix_en = 1'b0;
        bg_opaque = 1'b0;
        start_eval(8'd5);
        wait_ready("s0_keep", NOAM + NS + 3);
        n_tests++;
        if (sprite0_hit !== 1'b1) begin
            n_fail++;
            $display("FAIL s0_sticky: got %b, required 1", sprite0_hit);
        end
        start_eval(8'd0);
        wait_ready("s0_clear", NOAM + NS + 3);
        n_tests++;
        if (sprite0_hit !== 1'b0) begin
            n_fail++;
            $display("FAIL s0_clear: got %b, required 0", sprite0_hit);
        end
    endtask
`endif

    initial begin
        reset      = 1'b1;
        eval_start = 1'b0;
        eval_line  = 8'd0;
        line_go    = 1'b0;
        pix_en     = 1'b0;
`ifdef SPRITE_ZERO_HIT_EN
        bg_opaque  = 1'b0;
`endif
        for (int i = 0; i < 2048; i++) gfx[i] = $urandom;
        clear_oam(8'd0);
        test_reset();
        test_single();
        test_overflow();
        test_priority();
        test_wrap_flip();
        test_line_go_early();
        test_reset_mid();
        test_random();
`ifdef SPRITE_ZERO_HIT_EN
        test_sprite_zero();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ppu_sprite_line_engine.md
Name: ppu_sprite_line_engine

Overview:
- Parametrised per-scanline sprite engine for the PPU; generalises the fixed 8-shifter sprite path to NUM_SPRITES slots.
- In horizontal blank it scans OAM for the next line, selects up to NUM_SPRITES sprites and fetches one 16-pixel row of sprite graphics for each.
- During the active line it emits one prioritised 2-bit sprite pixel plus palette per pixel to the colour stage, where it is combined with the background.

Parameters:
- NUM_OAM, 64: OAM entries scanned, 1..256.
- NUM_SPRITES, 8: sprite slots per line, 1..32.
- OAM_AW, 8: OAM address width.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- eval_start  in  1  one-cycle pulse; begin evaluation of eval_line
- eval_line  in  8  scanline to prepare; sampled on eval_start
- line_go  in  1  one-cycle pulse at start of active line; swap prepared set in, x counter := 0
- pix_en  in  1  advance one pixel
- oam_addr  out  OAM_AW  OAM read address
- oam_rdata  in  32  OAM data, 1-cycle latency; [7:0] x, [15:8] y, [22:16] tile, [25:23] palette, [26] hflip, [27] vflip, rest ignored
- gfx_addr  out  11  sprite graphics address {tile[6:0], row[3:0]}
- gfx_rdata  in  32  graphics row, 1-cycle latency; pixel p = bits [2p+1:2p]
- busy  out  1  evaluation or fetch in progress
- ready  out  1  prepared set complete; cleared by eval_start or line_go
- overflow  out  1  more than NUM_SPRITES sprites hit eval_line; sticky until next eval_start
- pix_valid  out  1  registered pix_en
- pix_data  out  2  winning sprite pixel, 0 = transparent
- pix_palette  out  3  palette of winning sprite

Behaviour:
- Reset: state IDLE, all outputs 0, both slot banks invalid, x counter 0, oam_addr 0, gfx_addr 0.
- States: IDLE -> SCAN on eval_start; SCAN -> FETCH after the last OAM entry (NUM_OAM-1) result is checked; FETCH -> DONE after the last selected slot's data is captured; DONE -> IDLE in one cycle, which sets ready.
- With zero hits, FETCH takes 0 cycles.
- SCAN:
  - oam_addr steps 0..NUM_OAM-1, one per cycle, pipelined.
  - Entry hits if (eval_line - y) mod 256 < 16 (8-bit unsigned subtract).
  - Hits fill slots in OAM order.
  - A hit while all slots are full sets overflow; scanning continues to the end.
- FETCH:
  - Per filled slot: row = eval_line - y, inverted (15 - row) if vflip.
  - gfx_addr = {tile, row}; capture gfx_rdata 1 cycle later, pipelined one slot per cycle.
- Worst case: NUM_OAM + NUM_SPRITES + 3 cycles from eval_start to ready.
- eval_start while busy: ignored.
- eval_start in IDLE: clears the prepared bank, ready and overflow.
- line_go:
  - Copies the prepared bank to the active bank when ready = 1.
  - Otherwise the active bank becomes all-invalid.
  - Clears ready. The prepared bank is retained.
  - Resets the x counter to 0.
- line_go coincident with eval_start: line_go swap happens first, then evaluation starts.
- Active line:
  - On pix_en, for each valid slot with 0 <= x_cnt - x < 16 (9-bit compare): p = x_cnt - x, mirrored (15 - p) if hflip; candidate = 2-bit pixel p.
  - Winner: lowest slot index with a non-zero candidate.
  - pix_data and pix_palette are registered, 1-cycle latency; both are 0 when there is no winner.
  - x_cnt then increments and saturates at 511.
- Sprite x = 250: the slot covers x_cnt 250..265, with no wrap to x 0.
- pix_en = 0: pix_valid = 0, pix_data and pix_palette hold.
- Reset mid-scan: immediate return to IDLE; ready = 0, both banks invalid.

Optional Feature:
- Macro: SPRITE_ZERO_HIT_EN.
- Defined:
  - Adds input bg_opaque (1) and output sprite0_hit (1).
  - sprite0_hit is set when OAM entry 0 occupies an active slot, its candidate is non-zero, and bg_opaque = 1 on the same pix_en cycle.
  - Registered, sticky; cleared by reset or eval_start with eval_line = 0.
- Undefined: neither port exists; no sprite-0 tracking logic.

Test Plan:
- NUM_OAM = 64. Entry 5: y = 10, x = 20, tile 3, palette 2, row data 0x5555_5555. eval_line = 12 -> gfx_addr = 0x032; after line_go, pix_data = 1 and palette = 2 for x_cnt 20..35, and 0 at x_cnt 19 and 36.
- Ten entries all with y = 0, eval_line = 0, NUM_SPRITES = 8 -> slots hold entries 0..7, overflow = 1, ready asserted within 75 cycles of eval_start.
- Entries 2 and 7 overlap at x = 40. Entry 2 row = 0, entry 7 row = 0xFFFF_FFFF -> pix_data = 3 from entry 7. Then set entry 2 row = 0xAAAA_AAAA -> pix_data = 2, entry 2 wins.
- Entry y = 250, eval_line = 3 -> row 9 (wrap hit). Same entry with vflip -> row 6. Row with only pixel 0 = 3, hflip, x = 0 -> opaque at x_cnt 15 only.
- line_go before ready -> all pix_data = 0 for that line. Reset asserted mid-SCAN -> busy = 0 and ready = 0 next cycle, and the next line is transparent.
- SPRITE_ZERO_HIT_EN: entry 0 opaque at x_cnt 30, bg_opaque = 1 only at x_cnt 30 -> sprite0_hit rises 1 cycle later and holds until eval_start with eval_line = 0.
